// File: rtl/network_sequencer_if.sv
// Handshake bundle between the network sequencer (master) and the
// host / layer engines (slave).
interface network_sequencer_if #(
    parameter int NUM_LAYERS = 2
);
    logic                  start;
    logic                  fill;
    logic [NUM_LAYERS-1:0] layer_req;
    logic [NUM_LAYERS-1:0] layer_ack;
    logic [2:0]            layer_idx;
    logic                  busy;
    logic                  ack_network;
    logic                  timeout_err;
    logic [15:0]           run_cycles;

    modport master (
        input  start, layer_ack,
        output fill, layer_req, layer_idx, busy, ack_network, timeout_err, run_cycles
    );

    modport slave (
        output start, layer_ack,
        input  fill, layer_req, layer_idx, busy, ack_network, timeout_err, run_cycles
    );
endinterface

// File: rtl/network_sequencer.sv
// Sequences one network evaluation: input fill, then a req/ack handshake per
// layer with a per-layer watchdog. Moore FSM; all outputs decode registered state.
module network_sequencer #(
    parameter int NUM_LAYERS = 2,
    parameter int FILL_LEN   = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic clk,
    input  logic rst,
    network_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_REQ, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t                state_reg, state_next;
    logic [7:0]            fill_cnt_reg;
    logic [2:0]            layer_idx_reg;
    logic [15:0]           wdog_reg;
    logic [15:0]           run_cnt_reg;
    logic [15:0]           run_cycles_reg;
    logic                  timeout_err_reg;

    logic [NUM_LAYERS-1:0] layer_sel;
    logic                  ack_hit;
    logic                  last_layer;
    logic                  fill_last;
    logic                  wdog_expired;
    logic [15:0]           run_cnt_inc;

    // One-hot decode of the current layer; used both for the req pulse and
    // to mask out acks from layers we are not waiting on.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_sel
            assign layer_sel[gi] = (layer_idx_reg == 3'(gi));
        end
    endgenerate

    assign ack_hit      = |(bus.layer_ack & layer_sel);
    assign last_layer   = (layer_idx_reg == 3'(NUM_LAYERS - 1));
    assign fill_last    = (fill_cnt_reg == 8'(FILL_LEN - 1));
    assign wdog_expired = (wdog_reg == 16'(TIMEOUT - 1));
    assign run_cnt_inc  = (run_cnt_reg == 16'hFFFF) ? run_cnt_reg : run_cnt_reg + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.start) state_next = S_FILL;
            S_FILL: if (fill_last) state_next = S_REQ;
            S_REQ:  state_next = S_WAIT;
            // A matching ack on the expiry cycle takes precedence over the timeout.
            S_WAIT: begin
                if (ack_hit)           state_next = last_layer ? S_DONE : S_REQ;
                else if (wdog_expired) state_next = S_ERR;
            end
            S_DONE: state_next = S_IDLE;
            S_ERR:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_reg    <= '0;
            layer_idx_reg   <= '0;
            wdog_reg        <= '0;
            run_cnt_reg     <= '0;
            run_cycles_reg  <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        fill_cnt_reg    <= '0;
                        layer_idx_reg   <= '0;
                        wdog_reg        <= '0;
                        run_cnt_reg     <= 16'd1;
                        timeout_err_reg <= 1'b0;
                    end
                end
                S_FILL: begin
                    fill_cnt_reg <= fill_cnt_reg + 8'd1;
                    run_cnt_reg  <= run_cnt_inc;
                end
                S_REQ: begin
                    wdog_reg    <= '0;
                    run_cnt_reg <= run_cnt_inc;
                end
                S_WAIT: begin
                    run_cnt_reg <= run_cnt_inc;
                    if (ack_hit) begin
                        if (!last_layer) layer_idx_reg <= layer_idx_reg + 3'd1;
                    end else begin
                        wdog_reg <= wdog_reg + 16'd1;
                        if (wdog_expired) timeout_err_reg <= 1'b1;
                    end
                end
                S_DONE, S_ERR: run_cycles_reg <= run_cnt_reg;
                default: ;
            endcase
        end
    end

    assign bus.fill        = (state_reg == S_FILL);
    assign bus.layer_req   = (state_reg == S_REQ) ? layer_sel : '0;
    assign bus.layer_idx   = layer_idx_reg;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.ack_network = (state_reg == S_DONE);
    assign bus.timeout_err = timeout_err_reg;
    assign bus.run_cycles  = run_cycles_reg;
endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer with NUM_LAYERS=2, FILL_LEN=2, TIMEOUT=8.
// Inputs change and outputs are sampled on the falling edge; "cN" is cycle N of a run.
module tb_network_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic seen;

    always #5 clk = ~clk;

    network_sequencer_if #(.NUM_LAYERS(2)) bus ();

    network_sequencer #(
        .NUM_LAYERS(2),
        .FILL_LEN  (2),
        .TIMEOUT   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.layer_ack = 2'b00;
        repeat (3) @(posedge clk);
        step();
        chk("rst_busy",   bus.busy, 0);
        chk("rst_fill",   bus.fill, 0);
        chk("rst_req",    bus.layer_req, 0);
        chk("rst_ack",    bus.ack_network, 0);
        chk("rst_err",    bus.timeout_err, 0);
        chk("rst_cycles", bus.run_cycles, 0);
        rst = 1'b0;

        // Nominal run, each ack one cycle after its req
        step(); bus.start = 1'b1;                                 // c0
        step(); bus.start = 1'b0;                                 // c1
        chk("nom_fill_c1", bus.fill, 1);
        chk("nom_busy_c1", bus.busy, 1);
        step(); chk("nom_fill_c2", bus.fill, 1);                  // c2
        step();                                                   // c3
        chk("nom_fill_c3", bus.fill, 0);
        chk("nom_req_c3",  bus.layer_req, 2'b01);
        chk("nom_idx_c3",  bus.layer_idx, 0);
        step(); chk("nom_req_c4", bus.layer_req, 0); bus.layer_ack = 2'b01;   // c4
        step(); bus.layer_ack = 2'b00;                            // c5
        chk("nom_req_c5", bus.layer_req, 2'b10);
        chk("nom_idx_c5", bus.layer_idx, 1);
        step(); bus.layer_ack = 2'b10; chk("nom_done_c6", bus.ack_network, 0); // c6
        step(); bus.layer_ack = 2'b00; chk("nom_done_c7", bus.ack_network, 1); // c7
        step();                                                   // c8
        chk("nom_done_c8", bus.ack_network, 0);
        chk("nom_busy_c8", bus.busy, 0);
        chk("nom_cycles",  bus.run_cycles, 7);

        // Timeout: layer 1 never acks
        bus.start = 1'b1;                                         // c0
        step(); bus.start = 1'b0;                                 // c1
        step(); step();                                           // c3
        chk("to_req_c3", bus.layer_req, 2'b01);
        step(); bus.layer_ack = 2'b01;                            // c4
        step(); bus.layer_ack = 2'b00;                            // c5
        chk("to_req_c5", bus.layer_req, 2'b10);
        seen = 1'b0;
        for (int i = 6; i <= 13; i++) begin
            step();
            seen = seen | bus.ack_network;
        end
        chk("to_busy_c13", bus.busy, 1);
        chk("to_err_c13",  bus.timeout_err, 0);
        step(); seen = seen | bus.ack_network;                    // c14 (ERR)
        chk("to_busy_c14", bus.busy, 1);
        step();                                                   // c15
        chk("to_busy_c15", bus.busy, 0);
        chk("to_err_c15",  bus.timeout_err, 1);
        chk("to_idx_c15",  bus.layer_idx, 1);
        chk("to_cycles",   bus.run_cycles, 14);
        chk("to_no_ack",   seen, 0);

        // Ack on the expiry cycle of layer 0; new start clears timeout_err
        bus.start = 1'b1;                                         // c0
        step(); bus.start = 1'b0;                                 // c1
        chk("ex_err_clr", bus.timeout_err, 0);
        chk("ex_idx_c1",  bus.layer_idx, 0);
        step(); step();                                           // c3
        chk("ex_req_c3", bus.layer_req, 2'b01);
        for (int i = 4; i <= 10; i++) step();                     // WAIT c4..c10
        step(); bus.layer_ack = 2'b01;                            // c11, 8th WAIT cycle
        step(); bus.layer_ack = 2'b00;                            // c12
        chk("ex_req_c12", bus.layer_req, 2'b10);
        chk("ex_err_c12", bus.timeout_err, 0);
        step(); bus.layer_ack = 2'b10;                            // c13
        step(); bus.layer_ack = 2'b00;                            // c14
        chk("ex_done_c14", bus.ack_network, 1);
        step();                                                   // c15
        chk("ex_cycles", bus.run_cycles, 14);
        chk("ex_err_end", bus.timeout_err, 0);

        // Wrong-layer ack and start while busy, both ignored
        bus.start = 1'b1;                                         // c0
        step(); bus.start = 1'b0;                                 // c1
        step(); step();                                           // c3
        step(); bus.layer_ack = 2'b10; bus.start = 1'b1;          // c4
        step(); bus.layer_ack = 2'b00; bus.start = 1'b0;          // c5
        chk("wl_req_c5",  bus.layer_req, 0);
        chk("wl_idx_c5",  bus.layer_idx, 0);
        chk("wl_busy_c5", bus.busy, 1);
        chk("wl_fill_c5", bus.fill, 0);
        bus.layer_ack = 2'b01;
        step(); bus.layer_ack = 2'b00;                            // c6
        chk("wl_req_c6", bus.layer_req, 2'b10);
        step(); bus.layer_ack = 2'b10;                            // c7
        step(); bus.layer_ack = 2'b00;                            // c8
        chk("wl_done_c8", bus.ack_network, 1);
        step();                                                   // c9
        chk("wl_cycles", bus.run_cycles, 8);

        // rst at c4 beats a simultaneous ack and start
        bus.start = 1'b1;                                         // c0
        step(); bus.start = 1'b0;                                 // c1
        step(); step();                                           // c3
        chk("rs_req_c3", bus.layer_req, 2'b01);
        step(); rst = 1'b1; bus.layer_ack = 2'b01; bus.start = 1'b1;  // c4
        step(); rst = 1'b0; bus.layer_ack = 2'b00; bus.start = 1'b0;  // c5
        chk("rs_busy",   bus.busy, 0);
        chk("rs_fill",   bus.fill, 0);
        chk("rs_req",    bus.layer_req, 0);
        chk("rs_idx",    bus.layer_idx, 0);
        chk("rs_ack",    bus.ack_network, 0);
        chk("rs_err",    bus.timeout_err, 0);
        chk("rs_cycles", bus.run_cycles, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | (|bus.layer_req) | bus.busy;
        end
        chk("rs_quiet", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
